// File: rtl/l2_nexus_arbiter.sv
// l2_nexus_arbiter: two-L1 to one-L2 southbound arbiter.
// Per-port read/evict slots, write-first round-robin, fill return with hotlink hold-off.
module l2_nexus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_snooper_addr,
    input  logic [LINE_W-1:0] a_evictable_cacheline,
    input  logic              a_snooper_read_valid,
    input  logic              a_eviction_wren,
    input  logic              a_hotlink_interrupt,
    output logic [LINE_W-1:0] a_updated_cacheline,
    output logic              a_cacheline_update_valid,
    input  logic [ADDR_W-1:0] b_snooper_addr,
    input  logic [LINE_W-1:0] b_evictable_cacheline,
    input  logic              b_snooper_read_valid,
    input  logic              b_eviction_wren,
    input  logic              b_hotlink_interrupt,
    output logic [LINE_W-1:0] b_updated_cacheline,
    output logic              b_cacheline_update_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              overflow_err
);

    typedef enum logic [2:0] {IDLE, WREQ, RREQ, RWAIT, RESP} state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

    state_t state, state_nxt;

    logic       gnt, rr_ptr, sel, any_wr, any_rd;
    logic [1:0] rd_v, wr_v, cand;
    logic [1:0] rd_pulse, wr_pulse, hot, uv, clr_rd, clr_wr;

    logic [ADDR_W-1:0] in_addr [2];
    logic [ADDR_W-1:0] rd_addr [2];
    logic [ADDR_W-1:0] wr_addr [2];
    logic [LINE_W-1:0] in_line [2];
    logic [LINE_W-1:0] wr_line [2];
    logic [LINE_W-1:0] upd     [2];

    assign rd_pulse   = {b_snooper_read_valid, a_snooper_read_valid};
    assign wr_pulse   = {b_eviction_wren, a_eviction_wren};
    assign hot        = {b_hotlink_interrupt, a_hotlink_interrupt};
    assign in_addr[0] = a_snooper_addr;
    assign in_addr[1] = b_snooper_addr;
    assign in_line[0] = a_evictable_cacheline;
    assign in_line[1] = b_evictable_cacheline;

    assign a_updated_cacheline      = upd[0];
    assign b_updated_cacheline      = upd[1];
    assign a_cacheline_update_valid = uv[0];
    assign b_cacheline_update_valid = uv[1];

    // Writes outrank reads; rr_ptr only breaks ties within one class.
    always_comb begin
        any_wr = |wr_v;
        any_rd = |rd_v;
        cand   = any_wr ? wr_v : rd_v;
        sel    = (&cand) ? rr_ptr : cand[1];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any_wr)      state_nxt = WREQ;
                else if (any_rd) state_nxt = RREQ;
            end
            WREQ:  if (mem_ack)     state_nxt = IDLE;
            RREQ:  if (mem_ack)     state_nxt = RWAIT;
            RWAIT: if (mem_rvalid)  state_nxt = RESP;
            RESP:  if (!hot[gnt])   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == WREQ) || (state == RREQ);
        uv      = 2'b00;
        clr_wr  = 2'b00;
        if (state == RESP) uv[gnt] = ~hot[gnt];
        if (state == WREQ && mem_ack) clr_wr[gnt] = 1'b1;
        clr_rd = uv;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt          <= 1'b0;
            rr_ptr       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overflow_err <= 1'b0;
            rd_v         <= 2'b00;
            wr_v         <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                rd_addr[p] <= '0;
                wr_addr[p] <= '0;
                wr_line[p] <= '0;
                upd[p]     <= '0;
            end
        end else begin
            if (state == IDLE && (any_wr || any_rd)) begin
                gnt    <= sel;
                rr_ptr <= ~sel;
                mem_we <= any_wr;
                if (any_wr) begin
                    mem_addr  <= wr_addr[sel] & LINE_MASK;
                    mem_wdata <= wr_line[sel];
                end else begin
                    mem_addr  <= rd_addr[sel] & LINE_MASK;
                end
            end
            if (state == RWAIT && mem_rvalid) upd[gnt] <= mem_rdata;
            // A slot being cleared this cycle counts as free for a new pulse.
            for (int p = 0; p < 2; p++) begin
                if (rd_pulse[p]) begin
                    if (rd_v[p] && !clr_rd[p]) begin
                        overflow_err <= 1'b1;
                    end else begin
                        rd_v[p]    <= 1'b1;
                        rd_addr[p] <= in_addr[p];
                    end
                end else if (clr_rd[p]) begin
                    rd_v[p] <= 1'b0;
                end
                if (wr_pulse[p]) begin
                    if (wr_v[p] && !clr_wr[p]) begin
                        overflow_err <= 1'b1;
                    end else begin
                        wr_v[p]    <= 1'b1;
                        wr_addr[p] <= in_addr[p];
                        wr_line[p] <= in_line[p];
                    end
                end else if (clr_wr[p]) begin
                    wr_v[p] <= 1'b0;
                end
            end
        end
    end

endmodule
